// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller with architectural HI/LO registers.
//
// An operation issued in IDLE computes its result immediately into a shadow
// HI/LO pair, then holds the unit BUSY for a fixed latency (5 cycles for
// mult/multu, 10 for div/divu) before committing the shadow to HI/LO.
// mthi/mtlo write HI/LO directly when the unit is idle and no start is issued.
//
// Optional feature: define MDU_ABORT_EN to add the abort_i input, which
// cancels an in-flight operation without touching HI/LO.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      synchronous active-high reset
//   start_i      issue a mult/multu/div/divu (one cycle)
//   op_i         0=mult 1=multu 2=div 3=divu
//   src_a_i      rs operand (also the mthi/mtlo source)
//   src_b_i      rt operand
//   mthi_i       write src_a_i to HI
//   mtlo_i       write src_a_i to LO
//   d_md_use_i   D-stage instruction uses the MDU
//   abort_i      (MDU_ABORT_EN only) cancel in-flight operation
//   hi_o, lo_o   architectural HI/LO
//   busy_o       operation in flight
//   md_stall_o   stall request to the hazard controller
module mdu_ctrl (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic        d_md_use_i,
`ifdef MDU_ABORT_EN
  input  logic        abort_i,
`endif
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        md_stall_o
);

  localparam logic [1:0] OpMult = 2'd0;
  localparam logic [1:0] OpDiv  = 2'd2;
  localparam logic [3:0] MulCycles = 4'd5;
  localparam logic [3:0] DivCycles = 4'd10;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;

  logic        abort;
`ifdef MDU_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  // Result datapath
  logic        mul_sgn, div_sgn, neg_a, neg_b, div_by_zero;
  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] abs_a, abs_b, uq, ur, quot, rem;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    // Sign-extend only for signed mult; low 64 bits of the 64x64 product are
    // then the correct two's-complement result for both variants.
    mul_sgn = (op_i == OpMult);
    mul_a   = {{32{mul_sgn & src_a_i[31]}}, src_a_i};
    mul_b   = {{32{mul_sgn & src_b_i[31]}}, src_b_i};
    prod    = mul_a * mul_b;

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign.
    div_sgn     = (op_i == OpDiv);
    neg_a       = div_sgn & src_a_i[31];
    neg_b       = div_sgn & src_b_i[31];
    abs_a       = neg_a ? (32'd0 - src_a_i) : src_a_i;
    abs_b       = neg_b ? (32'd0 - src_b_i) : src_b_i;
    div_by_zero = (src_b_i == 32'd0);
    uq          = div_by_zero ? 32'd0 : (abs_a / abs_b);
    ur          = div_by_zero ? 32'd0 : (abs_a % abs_b);
    quot        = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    rem         = neg_a ? (32'd0 - ur) : ur;

    if (op_i[1]) begin
      // Divide by zero commits the current HI/LO, i.e. leaves them unchanged;
      // HI/LO cannot move while busy, so sampling them now is sufficient.
      res_hi = div_by_zero ? hi_q : rem;
      res_lo = div_by_zero ? lo_q : quot;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          // abort alongside start drops the start; start always drops moves
          if (!abort) begin
            sh_hi_d = res_hi;
            sh_lo_d = res_lo;
            cnt_d   = op_i[1] ? DivCycles : MulCycles;
            state_d = StBusy;
          end
        end else begin
          if (mthi_i) hi_d = src_a_i;
          if (mtlo_i) lo_d = src_a_i;
        end
      end
      StBusy: begin
        if (abort) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
          sh_hi_d = 32'd0;
          sh_lo_d = 32'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            hi_d    = sh_hi_q;
            lo_d    = sh_lo_q;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      sh_hi_q <= 32'd0;
      sh_lo_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
    end
  end

  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign busy_o     = (state_q == StBusy);
  assign md_stall_o = d_md_use_i & (start_i | busy_o);

endmodule
